axi_delay_counter_seq: RTL and testbench

AXI4-Lite master sequencer that programs and supervises one axi_delay_counter peripheral over its S00_AXI slave port.
- Accepts a delay request on a valid/ready interface.
- Writes the delay and start registers, then polls status until done or timeout.
- Reports completion or error with a one-cycle pulse.
- Sits between the interrupt-generation fabric and the delay counter, replacing CPU-driven register sequencing.

---
 rtl/axi_delay_counter_seq.sv | 217 +++++++++++++++++++++
 tb/tb_axi_delay_counter_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_delay_counter_seq.sv
// AXI4-Lite master that programs one delay counter peripheral (DELAY, then CTRL.start)
// and polls its STATUS register until done, a bus error, or the poll budget runs out.
module axi_delay_counter_seq #(
   parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
   parameter int          POLL_GAP      = 16,
   parameter int          TIMEOUT_POLLS = 1024
) (
   input  logic        ACLK,
   input  logic        ARESETN,

   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_delay,
   output logic        done_pulse,
   output logic        err_pulse,
   output logic [1:0]  err_code,
   output logic        busy,

   output logic [31:0] M_AXI_AWADDR,
   output logic [2:0]  M_AXI_AWPROT,
   output logic        M_AXI_AWVALID,
   input  logic        M_AXI_AWREADY,
   output logic [31:0] M_AXI_WDATA,
   output logic [3:0]  M_AXI_WSTRB,
   output logic        M_AXI_WVALID,
   input  logic        M_AXI_WREADY,
   input  logic [1:0]  M_AXI_BRESP,
   input  logic        M_AXI_BVALID,
   output logic        M_AXI_BREADY,
   output logic [31:0] M_AXI_ARADDR,
   output logic [2:0]  M_AXI_ARPROT,
   output logic        M_AXI_ARVALID,
   input  logic        M_AXI_ARREADY,
   input  logic [31:0] M_AXI_RDATA,
   input  logic [1:0]  M_AXI_RRESP,
   input  logic        M_AXI_RVALID,
   output logic        M_AXI_RREADY
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_DLY,
      S_WR_START,
      S_POLL_WAIT,
      S_POLL_RD
   } state_t;

   localparam logic [1:0]  ERR_NONE    = 2'd0;
   localparam logic [1:0]  ERR_BRESP   = 2'd1;
   localparam logic [1:0]  ERR_RRESP   = 2'd2;
   localparam logic [1:0]  ERR_TIMEOUT = 2'd3;

   localparam logic [31:0] CTRL_ADDR   = BASE_ADDR;
   localparam logic [31:0] DELAY_ADDR  = BASE_ADDR + 32'h4;
   localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'h8;

   // A zero gap bypasses POLL_WAIT entirely, so GAP_LAST only matters when GAP_EN is set.
   localparam bit          GAP_EN      = (POLL_GAP > 0);
   localparam logic [15:0] GAP_LAST    = GAP_EN ? 16'(POLL_GAP - 1) : 16'd0;
   localparam logic [15:0] POLL_LIMIT  = 16'(TIMEOUT_POLLS);

   state_t      state_reg,      state_next;
   logic [31:0] delay_reg,      delay_next;
   logic        aw_done_reg,    aw_done_next;
   logic        w_done_reg,     w_done_next;
   logic        ar_done_reg,    ar_done_next;
   logic [15:0] gap_cnt_reg,    gap_cnt_next;
   logic [15:0] poll_cnt_reg,   poll_cnt_next;
   logic [1:0]  err_code_reg,   err_code_next;
   logic        done_pulse_reg, done_pulse_next;
   logic        err_pulse_reg,  err_pulse_next;

   logic        wr_phase;
   logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic [15:0] poll_cnt_inc;
   logic        unused_rdata_bits;

   assign unused_rdata_bits = ^M_AXI_RDATA[31:1];

   // All bus outputs decode from registered state only; no READY-to-VALID paths.
   assign wr_phase      = (state_reg == S_WR_DLY) || (state_reg == S_WR_START);
   assign M_AXI_AWVALID = wr_phase && !aw_done_reg;
   assign M_AXI_WVALID  = wr_phase && !w_done_reg;
   assign M_AXI_BREADY  = wr_phase && aw_done_reg && w_done_reg;
   assign M_AXI_AWADDR  = (state_reg == S_WR_START) ? CTRL_ADDR : DELAY_ADDR;
   assign M_AXI_WDATA   = (state_reg == S_WR_START) ? 32'h0000_0001 : delay_reg;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_WSTRB   = 4'hF;
   assign M_AXI_ARVALID = (state_reg == S_POLL_RD) && !ar_done_reg;
   assign M_AXI_RREADY  = (state_reg == S_POLL_RD) && ar_done_reg;
   assign M_AXI_ARADDR  = STATUS_ADDR;
   assign M_AXI_ARPROT  = 3'b000;

   assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
   assign w_hs  = M_AXI_WVALID  && M_AXI_WREADY;
   assign b_hs  = M_AXI_BREADY  && M_AXI_BVALID;
   assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
   assign r_hs  = M_AXI_RREADY  && M_AXI_RVALID;
   assign poll_cnt_inc = poll_cnt_reg + 16'd1;

   // The pulse cycle is spent in IDLE with req_ready still low, so the earliest
   // new accept is one cycle after done_pulse/err_pulse.
   assign req_ready  = (state_reg == S_IDLE) && !done_pulse_reg && !err_pulse_reg;
   assign busy       = (state_reg != S_IDLE);
   assign done_pulse = done_pulse_reg;
   assign err_pulse  = err_pulse_reg;
   assign err_code   = err_code_reg;

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_reg      <= S_IDLE;
         delay_reg      <= 32'd0;
         aw_done_reg    <= 1'b0;
         w_done_reg     <= 1'b0;
         ar_done_reg    <= 1'b0;
         gap_cnt_reg    <= 16'd0;
         poll_cnt_reg   <= 16'd0;
         err_code_reg   <= ERR_NONE;
         done_pulse_reg <= 1'b0;
         err_pulse_reg  <= 1'b0;
      end else begin
         state_reg      <= state_next;
         delay_reg      <= delay_next;
         aw_done_reg    <= aw_done_next;
         w_done_reg     <= w_done_next;
         ar_done_reg    <= ar_done_next;
         gap_cnt_reg    <= gap_cnt_next;
         poll_cnt_reg   <= poll_cnt_next;
         err_code_reg   <= err_code_next;
         done_pulse_reg <= done_pulse_next;
         err_pulse_reg  <= err_pulse_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      delay_next      = delay_reg;
      aw_done_next    = aw_done_reg;
      w_done_next     = w_done_reg;
      ar_done_next    = ar_done_reg;
      gap_cnt_next    = gap_cnt_reg;
      poll_cnt_next   = poll_cnt_reg;
      err_code_next   = err_code_reg;
      done_pulse_next = 1'b0;
      err_pulse_next  = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (req_valid && req_ready) begin
               delay_next    = req_delay;
               err_code_next = ERR_NONE;
               poll_cnt_next = 16'd0;
               aw_done_next  = 1'b0;
               w_done_next   = 1'b0;
               state_next    = S_WR_DLY;
            end
         end

         S_WR_DLY, S_WR_START: begin
            if (aw_hs) aw_done_next = 1'b1;
            if (w_hs)  w_done_next  = 1'b1;
            if (b_hs) begin
               aw_done_next = 1'b0;
               w_done_next  = 1'b0;
               if (M_AXI_BRESP != 2'b00) begin
                  err_code_next  = ERR_BRESP;
                  err_pulse_next = 1'b1;
                  state_next     = S_IDLE;
               end else if (state_reg == S_WR_DLY) begin
                  state_next = S_WR_START;
               end else begin
                  gap_cnt_next = 16'd0;
                  ar_done_next = 1'b0;
                  state_next   = GAP_EN ? S_POLL_WAIT : S_POLL_RD;
               end
            end
         end

         S_POLL_WAIT: begin
            if (gap_cnt_reg == GAP_LAST) begin
               state_next = S_POLL_RD;
            end else begin
               gap_cnt_next = gap_cnt_reg + 16'd1;
            end
         end

         S_POLL_RD: begin
            if (ar_hs) ar_done_next = 1'b1;
            if (r_hs) begin
               ar_done_next  = 1'b0;
               poll_cnt_next = poll_cnt_inc;
               // A done status on the last allowed poll still counts as success.
               if (M_AXI_RRESP != 2'b00) begin
                  err_code_next  = ERR_RRESP;
                  err_pulse_next = 1'b1;
                  state_next     = S_IDLE;
               end else if (M_AXI_RDATA[0]) begin
                  done_pulse_next = 1'b1;
                  state_next      = S_IDLE;
               end else if (poll_cnt_inc == POLL_LIMIT) begin
                  err_code_next  = ERR_TIMEOUT;
                  err_pulse_next = 1'b1;
                  state_next     = S_IDLE;
               end else begin
                  gap_cnt_next = 16'd0;
                  state_next   = GAP_EN ? S_POLL_WAIT : S_POLL_RD;
               end
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_axi_delay_counter_seq.sv
// Bench for axi_delay_counter_seq: vector table of requests against a reactive AXI4-Lite
// slave model, with an ordered scoreboard of the bus transactions each request should cause.
module tb_axi_delay_counter_seq;

   localparam logic [31:0] BASE      = 32'hFFFF_FFF8;
   localparam int          GAP       = 16;
   localparam int          TMO       = 8;
   localparam logic [31:0] ADDR_CTRL = 32'hFFFF_FFF8;
   localparam logic [31:0] ADDR_DLY  = 32'hFFFF_FFFC;
   localparam logic [31:0] ADDR_STAT = 32'h0000_0000;
   localparam int          NVEC      = 9;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_delay = 32'd0;
   logic        done_pulse, err_pulse, busy;
   logic [1:0]  err_code;
   logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
   logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
   logic [3:0]  M_AXI_WSTRB;
   logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
   logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_BVALID = 1'b0;
   logic        M_AXI_ARREADY = 1'b0, M_AXI_RVALID = 1'b0;
   logic [1:0]  M_AXI_BRESP = 2'b00, M_AXI_RRESP = 2'b00;
   logic [31:0] M_AXI_RDATA = 32'd0;

   always #5 ACLK = ~ACLK;

   axi_delay_counter_seq #(
      .BASE_ADDR(BASE), .POLL_GAP(GAP), .TIMEOUT_POLLS(TMO)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .req_valid(req_valid), .req_ready(req_ready), .req_delay(req_delay),
      .done_pulse(done_pulse), .err_pulse(err_pulse), .err_code(err_code), .busy(busy),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
      .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   typedef struct {
      logic [31:0] delay;
      int          aw_lat, w_lat, ar_lat;
      int          not_done;   // status reads answering "not done" before done
      int          bresp_err;  // write index answered with SLVERR, -1 none
      int          rresp_err;  // read index answered with DECERR, -1 none
      logic [1:0]  exp_err;
      logic        exp_done;
      int          exp_reads;
      int          exp_lat;    // accept-to-pulse cycles, 0 = unchecked
   } vec_t;

   typedef struct {
      bit          is_rd;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   vec_t vecs [NVEC];
   txn_t sb_q [$];

   int n_checks = 0;
   int n_errors = 0;

   int cfg_aw_lat = 0, cfg_w_lat = 0, cfg_ar_lat = 0;
   int cfg_not_done = 0, cfg_bresp_err = -1, cfg_rresp_err = -1;
   int aw_wait = 0, w_wait = 0, ar_wait = 0;
   int wr_idx = 0, rd_idx = 0, ar_cnt = 0, cyc = 0, last_ar_cyc = 0;
   bit aw_got = 0, w_got = 0, ar_got = 0;
   bit hs_b = 0, hs_r = 0, prev_aw_hs = 0, prev_w_hs = 0, prev_ar_hs = 0;
   logic [31:0] aw_addr_c, w_data_c;
   logic [2:0]  aw_prot_c;
   logic [3:0]  w_strb_c;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge ACLK);
      #1;
   endtask

   task automatic push(input bit is_rd, input logic [31:0] addr, input logic [31:0] data);
      txn_t t;
      t.is_rd = is_rd;
      t.addr  = addr;
      t.data  = data;
      sb_q.push_back(t);
   endtask

   // Slave model, evaluated once per negedge: handshakes decided here complete at the next posedge.
   task automatic slave_step();
      txn_t e;
      cyc++;
      if (!ARESETN) begin
         M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0;
         M_AXI_ARREADY = 0; M_AXI_RVALID = 0;
         aw_got = 0; w_got = 0; ar_got = 0; aw_wait = 0; w_wait = 0; ar_wait = 0;
         hs_b = 0; hs_r = 0; prev_aw_hs = 0; prev_w_hs = 0; prev_ar_hs = 0;
         return;
      end
      if (hs_b) M_AXI_BVALID = 0;
      if (hs_r) M_AXI_RVALID = 0;
      if (prev_aw_hs) chk("awvalid_drop", M_AXI_AWVALID, 0);
      if (prev_w_hs)  chk("wvalid_drop",  M_AXI_WVALID,  0);
      if (prev_ar_hs) chk("arvalid_drop", M_AXI_ARVALID, 0);

      if (aw_got && w_got) begin
         $display("wr addr=%h data=%h strb=%h", aw_addr_c, w_data_c, w_strb_c);
         if (sb_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL sb_write: unexpected write addr=%h data=%h", aw_addr_c, w_data_c);
         end else begin
            e = sb_q.pop_front();
            chk("sb_write", {1'b0, aw_addr_c, w_data_c, w_strb_c, aw_prot_c},
                {e.is_rd, e.addr, e.data, 4'hF, 3'b000});
         end
         M_AXI_BVALID = 1;
         M_AXI_BRESP  = (wr_idx == cfg_bresp_err) ? 2'b10 : 2'b00;
         wr_idx++;
         aw_got = 0; w_got = 0;
      end
      if (ar_got) begin
         M_AXI_RVALID = 1;
         M_AXI_RDATA  = (rd_idx < cfg_not_done) ? 32'hFFFF_FFFE : 32'h0000_0001;
         M_AXI_RRESP  = (rd_idx == cfg_rresp_err) ? 2'b11 : 2'b00;
         rd_idx++;
         ar_got = 0;
      end

      M_AXI_AWREADY = M_AXI_AWVALID && !aw_got && (aw_wait >= cfg_aw_lat);
      if (M_AXI_AWVALID && !M_AXI_AWREADY) aw_wait++;
      M_AXI_WREADY = M_AXI_WVALID && !w_got && (w_wait >= cfg_w_lat);
      if (M_AXI_WVALID && !M_AXI_WREADY) w_wait++;
      M_AXI_ARREADY = M_AXI_ARVALID && !ar_got && !M_AXI_RVALID && (ar_wait >= cfg_ar_lat);
      if (M_AXI_ARVALID && !M_AXI_ARREADY) ar_wait++;

      prev_aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
      prev_w_hs  = M_AXI_WVALID && M_AXI_WREADY;
      prev_ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
      if (prev_aw_hs) begin
         aw_got = 1; aw_wait = 0; aw_addr_c = M_AXI_AWADDR; aw_prot_c = M_AXI_AWPROT;
      end
      if (prev_w_hs) begin
         w_got = 1; w_wait = 0; w_data_c = M_AXI_WDATA; w_strb_c = M_AXI_WSTRB;
      end
      if (prev_ar_hs) begin
         ar_got = 1; ar_wait = 0;
         $display("rd addr=%h", M_AXI_ARADDR);
         if (sb_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL sb_read: unexpected read addr=%h", M_AXI_ARADDR);
         end else begin
            e = sb_q.pop_front();
            chk("sb_read", {1'b1, M_AXI_ARADDR, M_AXI_ARPROT}, {e.is_rd, e.addr, 3'b000});
         end
         if (ar_cnt > 0) chk("poll_gap", (cyc - last_ar_cyc) > GAP, 1);
         last_ar_cyc = cyc;
         ar_cnt++;
      end
      hs_b = M_AXI_BVALID && M_AXI_BREADY;
      hs_r = M_AXI_RVALID && M_AXI_RREADY;
   endtask

   initial begin
      forever begin
         @(negedge ACLK);
         slave_step();
      end
   end

   function automatic vec_t mk(logic [31:0] d, int awl, int wl, int arl, int nd, int be, int re,
                               logic [1:0] ee, logic ed, int er, int el);
      vec_t v;
      v.delay = d; v.aw_lat = awl; v.w_lat = wl; v.ar_lat = arl;
      v.not_done = nd; v.bresp_err = be; v.rresp_err = re;
      v.exp_err = ee; v.exp_done = ed; v.exp_reads = er; v.exp_lat = el;
      return v;
   endfunction

   task automatic start_req(input vec_t v);
      int n;
      cfg_aw_lat = v.aw_lat; cfg_w_lat = v.w_lat; cfg_ar_lat = v.ar_lat;
      cfg_not_done = v.not_done; cfg_bresp_err = v.bresp_err; cfg_rresp_err = v.rresp_err;
      wr_idx = 0; rd_idx = 0; ar_cnt = 0;
      push(0, ADDR_DLY, v.delay);
      if (v.bresp_err != 0) push(0, ADDR_CTRL, 32'h1);
      for (int i = 0; i < v.exp_reads; i++) push(1, ADDR_STAT, 32'h0);
      n = 0;
      while (!req_ready && n < 50) begin tick(); n++; end
      chk("ready_before_req", req_ready, 1);
      req_valid = 1; req_delay = v.delay;
      tick();
      req_valid = 0; req_delay = 32'h0;
      chk("accept", {busy, req_ready, err_code}, {1'b1, 1'b0, 2'b00});
   endtask

   task automatic run_vec(input int id, input vec_t v);
      int n;
      start_req(v);
      n = 1;
      while (!(done_pulse || err_pulse) && n < 4000) begin tick(); n++; end
      if (n >= 4000) begin
         n_checks++; n_errors++;
         $display("FAIL vec%0d_timeout: no pulse after %0d cycles, required one", id, n);
      end
      if (v.exp_lat != 0) chk("latency", (n >= v.exp_lat - 1) && (n <= v.exp_lat + 1), 1);
      chk("outcome", {done_pulse, err_pulse, err_code, busy, req_ready},
          {v.exp_done, ~v.exp_done, v.exp_err, 1'b0, 1'b0});
      tick();
      chk("after_pulse", {done_pulse, err_pulse, err_code, busy, req_ready},
          {1'b0, 1'b0, v.exp_err, 1'b0, 1'b1});
      chk("read_count", rd_idx, v.exp_reads);
      chk("sb_left", sb_q.size(), 0);
      $display("vec %0d: delay=%h cycles=%0d reads=%0d err_code=%0d", id, v.delay, n, rd_idx, err_code);
   endtask

   initial begin
      int n;
      //           delay         awl wl arl  nd   be  re  err  done reads lat
      vecs[0] = mk(32'h0000_0064, 0, 0, 0,    0,  -1, -1, 2'd0, 1, 1,   22);
      vecs[1] = mk(32'h1234_5678, 3, 0, 0,    0,  -1, -1, 2'd0, 1, 1,   0);
      vecs[2] = mk(32'hA5A5_0001, 0, 3, 0,    0,  -1, -1, 2'd0, 1, 1,   0);
      vecs[3] = mk(32'h0000_0100, 0, 0, 0,    4,  -1, -1, 2'd0, 1, 5,   0);
      vecs[4] = mk(32'h0000_0200, 0, 0, 0, 1000,  -1, -1, 2'd3, 0, 8,   0);
      vecs[5] = mk(32'h0000_0300, 1, 1, 0,    0,   0, -1, 2'd1, 0, 0,   0);
      vecs[6] = mk(32'h0000_0400, 0, 0, 1,   10,  -1,  2, 2'd2, 0, 3,   0);
      vecs[7] = mk(32'h0000_0500, 2, 1, 0,    0,   1, -1, 2'd1, 0, 0,   0);
      vecs[8] = mk(32'hFFFF_FFFF, 0, 0, 2,    7,  -1, -1, 2'd0, 1, 8,   0);

      repeat (3) tick();
      chk("reset_state",
          {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
           req_ready, busy, done_pulse, err_pulse, err_code},
          {5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
      ARESETN = 1;
      tick();

      for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

      // Reset while a status read is stuck waiting for ARREADY.
      start_req(mk(32'h0000_0777, 0, 0, 1000, 1000, -1, -1, 2'd0, 0, 0, 0));
      n = 0;
      while (!M_AXI_ARVALID && n < 200) begin tick(); n++; end
      chk("arvalid_seen", M_AXI_ARVALID, 1);
      ARESETN = 0;
      tick();
      chk("reset_mid_poll",
          {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
           req_ready, busy, done_pulse, err_pulse, err_code},
          {5'b00000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00});
      $display("reset during poll: arvalid=%0d req_ready=%0d busy=%0d", M_AXI_ARVALID, req_ready, busy);
      ARESETN = 1;
      sb_q.delete();
      tick();
      run_vec(NVEC, vecs[0]);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
